// File: rtl/button_conditioner.sv
// Purpose: per-button 2-FF sync, counter debounce, press strobe and optional auto-repeat for the maze game buttons.
// Latency: btn_level and first btn_pulse DEBOUNCE_CYCLES+1 edges after a stable raw value is first sampled.
// Backpressure: none; btn_pulse/pulse_any are single-cycle strobes the consumer must take every cycle.
module button_conditioner #(
  parameter int                 NUM_BTN         = 5,
  parameter int                 DEBOUNCE_CYCLES = 1_000_000,
  parameter int                 HOLD_CYCLES     = 40_000_000,
  parameter int                 REPEAT_CYCLES   = 15_000_000,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = 5'b11110
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               pulse_any
);

  // One repeat counter serves both the hold and the repeat interval, so it is
  // sized for the larger of the two.
  localparam int REP_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] RPT_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] db_hit;      // debounce count completes at this edge
  logic [NUM_BTN-1:0] level_next;  // debounced level as of this edge
  logic [NUM_BTN-1:0] rep_due;     // hold/repeat interval expires at this edge
  logic [NUM_BTN-1:0] fire;        // strobe to register into btn_pulse

  logic [DB_W-1:0]  db_cnt  [NUM_BTN];
  logic [REP_W-1:0] rep_cnt [NUM_BTN];
  state_t           state   [NUM_BTN];

  // Decide per button whether the level flips, a repeat is due, and a strobe fires.
  // The FSM looks at level_next so the press pulse lands on the same edge the level rises,
  // and a release on a repeat-due edge suppresses the pulse.
  always_comb begin
    db_hit  = '0;
    rep_due = '0;
    fire    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_hit[i]  = (sync2[i] != btn_level[i]) && (db_cnt[i] == DB_LAST);
      rep_due[i] = ((state[i] == HOLD) && REPEAT_MASK[i] && (rep_cnt[i] == HOLD_LAST)) ||
                   ((state[i] == REPEAT) && (rep_cnt[i] == RPT_LAST));
    end
    level_next = btn_level ^ db_hit;
    for (int i = 0; i < NUM_BTN; i++) begin
      fire[i] = level_next[i] && ((state[i] == IDLE) || rep_due[i]);
    end
  end

  // Synchronize raw inputs and accept a new value only after it persists DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1     <= btn_raw;
      sync2     <= sync1;
      btn_level <= level_next;
      for (int i = 0; i < NUM_BTN; i++) begin
        // Any return to the accepted level, or an accepted change, restarts the count.
        if ((sync2[i] == btn_level[i]) || db_hit[i]) begin
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press / hold / auto-repeat state machine per button with registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_pulse <= '0;
      pulse_any <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i]   <= IDLE;
        rep_cnt[i] <= '0;
      end
    end else begin
      btn_pulse <= fire;
      pulse_any <= |fire;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          IDLE: begin
            if (level_next[i]) begin
              state[i]   <= HOLD;
              rep_cnt[i] <= '0;
            end
          end
          HOLD: begin
            if (!level_next[i]) begin
              state[i]   <= IDLE;
              rep_cnt[i] <= '0;
            end else if (!REPEAT_MASK[i]) begin
              // Non-repeating buttons park here until release.
              rep_cnt[i] <= '0;
            end else if (rep_due[i]) begin
              state[i]   <= REPEAT;
              rep_cnt[i] <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
          end
          REPEAT: begin
            if (!level_next[i]) begin
              state[i]   <= IDLE;
              rep_cnt[i] <= '0;
            end else if (rep_due[i]) begin
              rep_cnt[i] <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i]   <= IDLE;
            rep_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Purpose: self-checking bench for button_conditioner with short debounce/hold/repeat intervals.
// Latency: checks outputs on the falling edge after every rising edge.
// Backpressure: not applicable; the bench drives inputs every cycle.
module tb_button_conditioner;

  localparam int         NB   = 5;
  localparam int         DB   = 4;
  localparam int         HC   = 10;
  localparam int         RC   = 3;
  localparam logic [4:0] MASK = 5'b11110;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          pulse_any;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_CYCLES  (RC),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse),
    .pulse_any(pulse_any)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model. A button's level flips when the last DB values seen by the
  // debouncer (raw delayed by the two sync stages) all disagree with it. A pulse
  // occurs on a rise, and for repeat-enabled buttons at HC, HC+RC, HC+2RC, ...
  // edges after the rise while the level stays high.
  logic [4:0] rawq [$];
  logic [4:0] m_level;
  logic [4:0] m_pulse;
  logic       m_any;
  int         m_n;
  int         m_rise [NB];

  function automatic logic [4:0] seen(input int k);
    if (k + 2 < rawq.size()) return rawq[k + 2];
    return 5'h00;
  endfunction

  task automatic model_edge(input logic [4:0] raw, input logic rst);
    logic [4:0] nl;
    bit         all_diff;
    int         d;
    if (rst) begin
      rawq.delete();
      m_level = '0;
      m_pulse = '0;
      m_any   = 1'b0;
      m_n     = 0;
    end else begin
      rawq.push_front(raw);
      if (rawq.size() > DB + 2) void'(rawq.pop_back());
      nl = m_level;
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++) begin
          if (seen(k)[b] == m_level[b]) all_diff = 1'b0;
        end
        if (all_diff) nl[b] = ~m_level[b];
      end
      m_pulse = '0;
      for (int b = 0; b < NB; b++) begin
        if (nl[b]) begin
          if (!m_level[b]) begin
            m_pulse[b] = 1'b1;
            m_rise[b]  = m_n;
          end else if (MASK[b]) begin
            d = m_n - m_rise[b];
            if (d >= HC && ((d - HC) % RC) == 0) m_pulse[b] = 1'b1;
          end
        end
      end
      m_level = nl;
      m_any   = |m_pulse;
      m_n++;
    end
  endtask

  // One clock: drive inputs, advance the model on the rising edge, compare on the falling edge.
  task automatic tick(input logic [4:0] raw, input logic rst);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    model_edge(raw, rst);
    @(negedge clk);
    check("model_level", btn_level, m_level);
    check("model_pulse", btn_pulse, m_pulse);
    check("model_any", {4'b0, pulse_any}, {4'b0, m_any});
  endtask

  typedef struct {
    logic       rst;
    logic [4:0] raw;
    int         n;
    logic [4:0] lvl;
    logic [4:0] pls;
    logic       any;
  } vec_t;

  vec_t vt [$];

  task automatic add_vec(input logic rst, input logic [4:0] raw, input int n,
                         input logic [4:0] lvl, input logic [4:0] pls, input logic any);
    vec_t v;
    v.rst = rst; v.raw = raw; v.n = n; v.lvl = lvl; v.pls = pls; v.any = any;
    vt.push_back(v);
  endtask

  initial begin
    logic [4:0] cur;
    logic [4:0] flip;
    int         len;
    int         cnt_p;
    int         cnt_a;
    int         offs;
    logic       seen_lvl;
    logic [19:0] got_mask;
    logic [19:0] exp_mask;

    btn_raw = '0;
    reset   = 1'b1;

    // Each row: apply inputs for n edges, then expect these outputs.
    add_vec(1'b1, 5'h1F, 3, 5'h00, 5'h00, 1'b0);  // held during reset: all zero
    add_vec(1'b0, 5'h1F, 5, 5'h00, 5'h00, 1'b0);  // E0..E4 still debouncing
    add_vec(1'b0, 5'h1F, 1, 5'h1F, 5'h1F, 1'b1);  // E5: level + press pulse on all
    add_vec(1'b0, 5'h1F, 1, 5'h1F, 5'h00, 1'b0);  // E6: strobe lasts one cycle
    add_vec(1'b0, 5'h1F, 8, 5'h1F, 5'h00, 1'b0);  // E7..E14 holding
    add_vec(1'b0, 5'h1F, 1, 5'h1F, 5'h1E, 1'b1);  // E15: first repeat, C masked
    add_vec(1'b0, 5'h1F, 2, 5'h1F, 5'h00, 1'b0);  // E16..E17
    add_vec(1'b0, 5'h1F, 1, 5'h1F, 5'h1E, 1'b1);  // E18: repeat
    add_vec(1'b0, 5'h00, 2, 5'h1F, 5'h00, 1'b0);  // release sampled E19
    add_vec(1'b0, 5'h00, 1, 5'h1F, 5'h1E, 1'b1);  // E21: repeat while release debounces
    add_vec(1'b0, 5'h00, 2, 5'h1F, 5'h00, 1'b0);  // E22..E23
    add_vec(1'b0, 5'h00, 1, 5'h00, 5'h00, 1'b0);  // E24: release beats due repeat
    add_vec(1'b0, 5'h00, 3, 5'h00, 5'h00, 1'b0);
    add_vec(1'b0, 5'h18, 5, 5'h00, 5'h00, 1'b0);  // L and D together
    add_vec(1'b0, 5'h18, 1, 5'h18, 5'h18, 1'b1);  // coincident pulses
    add_vec(1'b0, 5'h18, 1, 5'h18, 5'h00, 1'b0);
    add_vec(1'b0, 5'h00, 8, 5'h00, 5'h00, 1'b0);  // release, no pulse

    for (int i = 0; i < vt.size(); i++) begin
      for (int c = 0; c < vt[i].n; c++) tick(vt[i].raw, vt[i].rst);
      check($sformatf("vec%0d_level", i), btn_level, vt[i].lvl);
      check($sformatf("vec%0d_pulse", i), btn_pulse, vt[i].pls);
      check($sformatf("vec%0d_any", i), {4'b0, pulse_any}, {4'b0, vt[i].any});
    end

    // R bounces with runs of 2 for 20 cycles: level must not move.
    seen_lvl = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick((((c / 2) % 2) == 0) ? 5'h04 : 5'h00, 1'b0);
      seen_lvl = seen_lvl | btn_level[2];
    end
    check("bounce_level", {4'b0, seen_lvl}, 5'h00);
    // Then stable: exactly one pulse, 5 edges after the first stable sample.
    offs  = -1;
    cnt_p = 0;
    for (int c = 0; c < 10; c++) begin
      tick(5'h04, 1'b0);
      if (btn_pulse[2]) begin
        cnt_p++;
        if (offs < 0) offs = c;
      end
    end
    check_int("bounce_pulse_edge", offs, DB + 1);
    check_int("bounce_pulse_count", cnt_p, 1);
    for (int c = 0; c < 8; c++) tick(5'h00, 1'b0);

    // C has repeat disabled: one pulse over a long hold.
    cnt_p = 0;
    cnt_a = 0;
    for (int c = 0; c < 60; c++) begin
      tick(5'h01, 1'b0);
      if (btn_pulse[0]) cnt_p++;
      if (pulse_any) cnt_a++;
    end
    check_int("c_hold_pulses", cnt_p, 1);
    check_int("c_hold_any", cnt_a, 1);
    for (int c = 0; c < 8; c++) tick(5'h00, 1'b0);

    // Reset while U is auto-repeating; U stays held and is seen as a fresh press.
    for (int c = 0; c < 20; c++) tick(5'h02, 1'b0);
    tick(5'h02, 1'b1);
    check("rst_mid_level", btn_level, 5'h00);
    check("rst_mid_pulse", btn_pulse, 5'h00);
    check("rst_mid_any", {4'b0, pulse_any}, 5'h00);
    got_mask = '0;
    for (int c = 0; c < 20; c++) begin
      tick(5'h02, 1'b0);
      got_mask[c] = btn_pulse[1];
    end
    exp_mask = '0;
    exp_mask[DB + 1]           = 1'b1;
    exp_mask[DB + 1 + HC]      = 1'b1;
    exp_mask[DB + 1 + HC + RC] = 1'b1;
    check_int("rst_mid_pulse_edges", int'(got_mask), int'(exp_mask));
    for (int c = 0; c < 8; c++) tick(5'h00, 1'b0);

    // Random segments with sparse bit flips, occasional long holds and resets.
    cur = '0;
    for (int s = 0; s < 300; s++) begin
      flip = 5'($urandom) & 5'($urandom);
      cur  = cur ^ flip;
      len  = $urandom_range(1, 14);
      if ($urandom_range(0, 5) == 0) len = $urandom_range(15, 40);
      if ($urandom_range(0, 39) == 0) tick(cur, 1'b1);
      for (int c = 0; c < len; c++) tick(cur, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
